regfile_mp: RTL

- Parametrised multi-port general-purpose register file for the Sirius integer core; next generation of the single-issue 2R/1W file.
- Provides NUM_RD combinational read ports, two prioritised write ports with write-through bypass, and a per-register pending scoreboard for RAW hazard detection in the ID stage.
- Adds a post-reset clear sequencer that zeroes the array, so no X values propagate from uninitialised storage.

---
 rtl/regfile_mp_pkg.sv | 23 ++
 rtl/regfile_mp_if.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_mp.sv | 125 ++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared register-file definitions for the Sirius integer core.
// Holds the core's register bus types and enables, plus the state
// encoding of the post-reset clear sequencer.
package regfile_mp_pkg;

  localparam int RegBusW    = 32;
  localparam int RegNumLog2 = 5;
  localparam int RegNum     = 2 ** RegNumLog2;

  typedef logic [RegBusW-1:0]    RegBus;
  typedef logic [RegNumLog2-1:0] RegAddrBus;

  localparam RegBus ZeroWord    = '0;
  localparam logic  WriteEnable = 1'b1;
  localparam logic  ReadEnable  = 1'b1;

  // CLEAR zeroes the array after reset; READY is terminal until rst.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle of the multi-port register file.
// Signal set: ready (status), two write ports (we/waddr/wdata 0 and 1),
// packed read ports (re/raddr/rdata/rpend) and the issue port
// (iss_valid/iss_addr) that marks a destination as pending.
// Handshake semantics: there is no backpressure. Writes, reads and issues
// take effect only while ready=1; while ready=0 the file ignores we0, we1
// and iss_valid and returns zero on rdata/rpend. The master must wait for
// ready before relying on any transfer.
// master: the pipeline driving the file; slave: regfile_mp.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) ();

  logic                     ready;
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rpend;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;

  modport master (
    input  ready, rdata, rpend,
    output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr,
           iss_valid, iss_addr
  );

  modport slave (
    output ready, rdata, rpend,
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr,
           iss_valid, iss_addr
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for RAW hazard detection.
// Ports: clk, rst (sync, active-high), w0/waddr0 and w1/waddr1 (qualified
// writes that retire a producer), iss/iss_addr (qualified issue that starts
// a producer), raddr (packed read addresses), pend_raw (pending bit of each
// read port's register, before bypass masking).
module regfile_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic                     w1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic                     iss,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        pend_raw
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;

  // Clears first, then the issue, so a same-cycle issue to a retiring
  // register keeps the bit set for the new producer. Entry 0 never pends.
  always_comb begin
    pend_d = pend_q;
    if (w0)  pend_d[waddr0]   = 1'b0;
    if (w1)  pend_d[waddr1]   = 1'b0;
    if (iss) pend_d[iss_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  always_comb begin
    pend_raw = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      pend_raw[i] = pend_q[raddr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file with post-reset clearing.
// Ports: clk, rst (sync, active-high), bus (regfile_mp_if slave: ready,
// two prioritised write ports, NUM_RD combinational read ports with
// write-through bypass, pending flags, issue port), dbg_state (clear
// sequencer state for observation).
// Write port 1 carries the younger instruction and wins every conflict.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = RegBusW,
  parameter int ADDR_W = RegNumLog2,
  parameter int NUM_RD = 2
) (
  input  logic       clk,
  input  logic       rst,
  regfile_mp_if.slave bus,
  output rf_state_e  dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be in 1..4");
    end
  endgenerate

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] regs [DEPTH];

  logic act, w0, w1, iss;
  logic [NUM_RD-1:0] pend_raw;

  // Everything user-visible is gated by act: nothing leaks out during rst
  // or while the array is still being cleared.
  assign act = (state_q == READY) && !rst;
  assign w0  = act && (bus.we0 == WriteEnable);
  assign w1  = act && (bus.we1 == WriteEnable);
  assign iss = act && bus.iss_valid;

  assign bus.ready = act;
  assign dbg_state = state_q;

  // Clear sequencer: entry 0 is skipped because it always reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= ADDR_W'(1);
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Storage has no reset; the clear sequence provides defined contents.
  // Port 1 is assigned last so it overrides port 0 on the same address.
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLEAR) begin
      regs[clr_idx_q] <= '0;
    end else begin
      if (w0 && bus.waddr0 != '0) regs[bus.waddr0] <= bus.wdata0;
      if (w1 && bus.waddr1 != '0) regs[bus.waddr1] <= bus.wdata1;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .w0       (w0),
    .waddr0   (bus.waddr0),
    .w1       (w1),
    .waddr1   (bus.waddr1),
    .iss      (iss),
    .iss_addr (bus.iss_addr),
    .raddr    (bus.raddr),
    .pend_raw (pend_raw)
  );

  logic [ADDR_W-1:0]        ra;
  logic                     byp0, byp1;
  logic [NUM_RD*DATA_W-1:0] rdata_v;
  logic [NUM_RD-1:0]        rpend_v;

  // A same-cycle write to the read address is forwarded, and since its
  // value is being delivered the register is not reported as pending.
  always_comb begin
    rdata_v = '0;
    rpend_v = '0;
    ra      = '0;
    byp0    = 1'b0;
    byp1    = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra   = bus.raddr[i*ADDR_W +: ADDR_W];
      byp1 = w1 && (bus.waddr1 == ra);
      byp0 = w0 && (bus.waddr0 == ra);
      if (act && bus.re[i] == ReadEnable && ra != '0) begin
        if (byp1)      rdata_v[i*DATA_W +: DATA_W] = bus.wdata1;
        else if (byp0) rdata_v[i*DATA_W +: DATA_W] = bus.wdata0;
        else           rdata_v[i*DATA_W +: DATA_W] = regs[ra];
        rpend_v[i] = pend_raw[i] && !(byp0 || byp1);
      end
    end
  end

  assign bus.rdata = rdata_v;
  assign bus.rpend = rpend_v;

endmodule
